// File: rtl/drop_spawner_pkg.sv
// Shared definitions for the drop spawner and its LFSR.
//   lfsr_taps  : Galois tap mask for the 16-bit right-shifting LFSR
//   state_e    : spawner FSM encoding (2 bits)
//   LvlW       : width of the difficulty level
//   gap_thr()  : per-level threshold below which a row is left empty
package drop_spawner_pkg;

  localparam logic [15:0] LfsrTaps = 16'hB400;
  localparam int unsigned LvlW     = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGen  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Higher levels leave fewer empty rows; level 3 never leaves one.
  function automatic logic [2:0] gap_thr(input logic [LvlW-1:0] lvl);
    logic [2:0] thr;
    unique case (lvl)
      2'd0:    thr = 3'd4;
      2'd1:    thr = 3'd2;
      2'd2:    thr = 3'd1;
      default: thr = 3'd0;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/drop_spawner_lfsr16.sv
// Free-running 16-bit Galois LFSR, shifting right.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, loads SEED
//   state_o : current LFSR state
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) state_d = state_d ^ TAPS;
    // The all-zero state would lock up; recover to the seed.
    if (state_q == 16'h0) state_d = SEED;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/drop_spawner.sv
// Pseudo-random drop-row generator feeding the action stage.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   e_spn_i : enable from top FSM, held until d_spn_o is seen
//   row_o   : new top row, empty or one-hot, valid while d_spn_o=1
//   d_spn_o : done, high in the DONE state
//   level_o : difficulty level 0..3, rises every LVL_STEP drops
module drop_spawner
  import drop_spawner_pkg::*;
#(
  parameter int unsigned GS       = 8,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int unsigned LVL_STEP = 16,
  parameter int unsigned MAX_LVL  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            e_spn_i,
  output logic [GS-1:0]   row_o,
  output logic            d_spn_o,
  output logic [LvlW-1:0] level_o
);

  localparam int unsigned CW   = $clog2(GS);
  localparam int unsigned CntW = $clog2(LVL_STEP + 1);

  state_e              state_q, state_d;
  logic [GS-1:0]       row_q, row_d;
  logic [CW-1:0]       last_col_q, last_col_d;
  logic [CntW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic [15:0]         lfsr;
  logic [CW-1:0]       col;
  logic                row_empty;
  logic                lfsr_unused;

  lfsr16 #(
    .SEED (SEED),
    .TAPS (LfsrTaps)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .state_o (lfsr)
  );

  assign lfsr_unused = ^lfsr;

  assign row_empty = lfsr[10:8] < gap_thr(level_q);

  // GS is a power of two, so CW-bit addition wraps GS-1 to 0.
  always_comb begin
    col = lfsr[CW-1:0];
    if (col == last_col_q) col = col + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    last_col_d = last_col_q;
    drop_cnt_d = drop_cnt_q;
    level_d    = level_q;
    unique case (state_q)
      StIdle: begin
        if (e_spn_i) state_d = StGen;
      end
      StGen: begin
        state_d = StDone;
        row_d   = '0;
        if (!row_empty) begin
          row_d[col] = 1'b1;
          last_col_d = col;
          if (drop_cnt_q == CntW'(LVL_STEP - 1)) begin
            drop_cnt_d = '0;
            if (level_q < LvlW'(MAX_LVL)) level_d = level_q + 1'b1;
          end else begin
            drop_cnt_d = drop_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (!e_spn_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      row_q      <= '0;
      last_col_q <= '0;
      drop_cnt_q <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      last_col_q <= last_col_d;
      drop_cnt_q <= drop_cnt_d;
      level_q    <= level_d;
    end
  end

  assign row_o   = row_q;
  assign d_spn_o = (state_q == StDone);
  assign level_o = level_q;

endmodule
